// File: rtl/monster_sprite_arbiter_pkg.sv
// monster_pkg: shared types and constants for the slug sprite ROM arbiter.
//
// Contents:
//   SPRITE_W / SPRITE_H / SPRITE_WORDS  sprite geometry (22x22 = 484 words)
//   COL_W / ROW_W / PIX_W / RSP_ID_W    field widths used on the response bus
//   arb_state_t                         arbiter FSM states (IDLE, BURST)
//   pixel_rsp_t                         one tagged pixel on the response bus
package monster_pkg;

  localparam int SPRITE_W     = 22;
  localparam int SPRITE_H     = 22;
  localparam int SPRITE_WORDS = SPRITE_W * SPRITE_H;
  localparam int COL_W        = 5;
  localparam int ROW_W        = 5;
  localparam int PIX_W        = 4;
  localparam int RSP_ID_W     = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [RSP_ID_W-1:0] id;
    logic [COL_W-1:0]    col;
    logic [PIX_W-1:0]    data;
    logic                last;
  } pixel_rsp_t;

endpackage

// File: rtl/monster_sprite_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   ID_W     index that has highest priority this round
//   winner  out  NUM_REQ  one-hot winner (all zero when no request)
//   index   out  ID_W     encoded winner index
//   any     out  1        at least one request is pending
module rr_picker #(
  parameter int NUM_REQ = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [ID_W-1:0]    index,
  output logic               any
);

  logic            found;
  logic [ID_W-1:0] slot;

  // Walk the requesters starting at ptr and wrapping; the first one found wins.
  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    slot   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[slot]) begin
        found        = 1'b1;
        winner[slot] = 1'b1;
        index        = slot;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/monster_sprite_arbiter.sv
// monster_sprite_arbiter: shares one read port of the slug sprite palette ROM
// among NUM_REQ monster render engines. Each grant streams one full sprite row
// (SPRITE_W addresses) into the ROM; returned pixels are tagged with requester
// id and column.
//
// Optional build macro: MONSTER_ARB_ROW_CHECK_EN
//   defined   - rows >= SPRITE_H still burst 22 pixels, but rom_addr is held
//               at 0 and rsp_data is forced to 0 (transparent).
//   undefined - no row check; the raw address goes to the ROM.
//
// Ports:
//   clk        in   1            system clock
//   rst_n      in   1            asynchronous active-low reset
//   req        in   NUM_REQ      level row-fetch requests
//   req_row    in   NUM_REQ*5    row index per requester, [5i+4:5i]
//   gnt        out  NUM_REQ      one-hot, one-cycle grant pulse
//   busy       out  1            burst in progress
//   rom_addr   out  ADDR_W       ROM read address
//   rom_data   in   4            ROM data, one cycle after rom_addr
//   rsp_valid  out  1            pixel response valid
//   rsp_id     out  ID_W         owner of the pixel
//   rsp_col    out  5            pixel column
//   rsp_data   out  4            palette index
//   rsp_last   out  1            last column of the row
module monster_sprite_arbiter
  import monster_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int ADDR_W  = 19,
  parameter int ID_W    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ROW_W-1:0] req_row,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [PIX_W-1:0]         rom_data,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [COL_W-1:0]         rsp_col,
  output logic [PIX_W-1:0]         rsp_data,
  output logic                     rsp_last
);

  arb_state_t        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [COL_W-1:0]  col;
  logic              oob_q;

  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [COL_W-1:0]  rsp_col_q;
  logic              rsp_last_q;
  logic              rsp_oob_q;

  logic [NUM_REQ-1:0] win_onehot;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;
  logic [ROW_W-1:0]   win_row;
  logic [ADDR_W-1:0]  win_base;
  logic [ID_W-1:0]    next_ptr;
  logic               win_oob;
  logic               last_col;
  pixel_rsp_t         rsp;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (win_onehot),
    .index  (win_idx),
    .any    (win_any)
  );

  // One-hot mux of the winner's row; avoids a variable part-select.
  always_comb begin
    win_row = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        win_row = req_row[i*ROW_W +: ROW_W];
      end
    end
  end

  assign win_base = ADDR_W'(win_row) * ADDR_W'(SPRITE_W);
  assign next_ptr = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
  assign last_col = (col == COL_W'(SPRITE_W - 1));

`ifdef MONSTER_ARB_ROW_CHECK_EN
  assign win_oob = (win_row >= ROW_W'(SPRITE_H));
`else
  assign win_oob = 1'b0;
`endif

  // Arbiter FSM plus the one-stage response pipeline that lines the tags up
  // with the ROM's registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      col         <= '0;
      oob_q       <= 1'b0;
      gnt         <= '0;
      busy        <= 1'b0;
      rom_addr    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_col_q   <= '0;
      rsp_last_q  <= 1'b0;
      rsp_oob_q   <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (win_any) begin
            state    <= BURST;
            cur_id   <= win_idx;
            gnt      <= win_onehot;
            col      <= '0;
            busy     <= 1'b1;
            oob_q    <= win_oob;
            rom_addr <= win_oob ? '0 : win_base;
            rr_ptr   <= next_ptr;
          end
        end
        BURST: begin
          if (last_col) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            col <= col + COL_W'(1);
            if (!oob_q) begin
              rom_addr <= rom_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      rsp_valid_q <= busy;
      rsp_id_q    <= cur_id;
      rsp_col_q   <= col;
      rsp_last_q  <= busy && last_col;
      rsp_oob_q   <= busy && oob_q;
    end
  end

  // rom_data arrives in the response cycle, so it is not registered here.
  always_comb begin
    rsp.valid = rsp_valid_q;
    rsp.id    = RSP_ID_W'(rsp_id_q);
    rsp.col   = rsp_col_q;
    rsp.data  = (rsp_valid_q && !rsp_oob_q) ? rom_data : '0;
    rsp.last  = rsp_last_q;
  end

  assign rsp_valid = rsp.valid;
  assign rsp_id    = ID_W'(rsp.id);
  assign rsp_col   = rsp.col;
  assign rsp_data  = rsp.data;
  assign rsp_last  = rsp.last;

endmodule
